image_frame_loader: RTL and testbench
=====================================

Name: image_frame_loader

Overview:
- Upstream frame loader for the image-processing processor system.
- Receives an 8-bit pixel stream and writes it into the processor's 256x16 data RAM. Holds the processor in reset while loading, then releases it.
- When the processor signals completion, reads the processed frame back from RAM and streams it out as 8-bit pixels.
- Sits between the external pixel source/sink and the RAM data port.

Parameters:
- IMG_WORDS, 256: pixels per frame (1..256); one pixel per RAM word.
- BASE_ADDR, 0: first RAM address of the frame buffer; addresses wrap modulo 256.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- start_load  input  1  begin frame load; sampled only in IDLE
- s_valid  input  1  input pixel valid
- s_ready  output  1  loader accepts input pixel
- s_data  input  8  input pixel
- cpu_hold  output  1  holds processor in reset; 1 = held
- cpu_done  input  1  processor finished; level, sampled only in RUN
- ram_we  output  1  RAM write strobe, registered
- ram_re  output  1  RAM read strobe, registered
- ram_addr  output  8  RAM address, registered
- ram_wdata  output  16  RAM write data, registered
- ram_rdata  input  16  RAM read data, valid 1 cycle after ram_re
- m_valid  output  1  output pixel valid
- m_ready  input  1  sink accepts output pixel
- m_data  output  8  output pixel
- busy  output  1  state != IDLE
- frame_done  output  1  one-cycle pulse after the last output pixel handshake

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, count=0.
  - s_ready=0, m_valid=0, m_data=0, ram_we=0, ram_re=0, ram_addr=BASE_ADDR, ram_wdata=0.
  - cpu_hold=1, busy=0, frame_done=0.
  - Reset mid-frame aborts immediately; no partial state survives.
- States: IDLE, LOAD, RUN, RD_ISSUE, RD_WAIT, OUT.
- IDLE:
  - cpu_hold=1.
  - start_load=1 -> LOAD, count=0.
- LOAD:
  - s_ready=1 combinationally.
  - On s_valid&s_ready: next cycle ram_we=1, ram_addr=(BASE_ADDR+count) mod 256, ram_wdata={8'h00,s_data}; count++.
  - ram_we=0 in cycles with no handshake.
  - Handshake with count==IMG_WORDS-1 -> RUN; s_ready=0 from the cycle after.
  - Throughput: 1 pixel/cycle.
- RUN:
  - cpu_hold=0; s_ready=0.
  - cpu_done=1 -> RD_ISSUE, count=0, cpu_hold=1 from the next cycle.
  - cpu_done seen in any other state is ignored.
- RD_ISSUE: ram_re=1, ram_addr=(BASE_ADDR+count) mod 256 for one cycle -> RD_WAIT.
- RD_WAIT: capture ram_rdata, convert to m_data (see Optional Feature), m_valid=1 -> OUT.
- OUT:
  - m_valid and m_data stay stable until m_ready.
  - On handshake: m_valid=0 and count++.
  - If count was IMG_WORDS-1: frame_done=1 for one cycle -> IDLE.
  - Otherwise -> RD_ISSUE.
  - Output throughput: 1 pixel per 3 cycles maximum.
- Simultaneous events:
  - start_load outside IDLE is ignored.
  - s_valid outside LOAD is ignored; no data is taken.
  - If m_ready is high when m_valid rises, the handshake completes that cycle.
- Width rules:
  - count is 9 bits, so IMG_WORDS=256 is representable.
  - Address is the 8-bit truncation of BASE_ADDR+count.
- ram_we and ram_re are never high in the same cycle.

Optional Feature:
- Macro: FRAME_OUT_SAT_EN.
- Defined: m_data = 8'hFF if ram_rdata > 255, else ram_rdata[7:0]. Saturation guards against ALU overflow in processed pixels.
- Undefined: m_data = ram_rdata[7:0] (plain truncation).

Test Plan:
- IMG_WORDS=4, BASE_ADDR=0x10; start_load, stream 0x11,0x22,0x33,0x44 back-to-back -> ram_we on 4 consecutive cycles, addr 0x10..0x13, wdata 0x0011..0x0044; s_ready drops after the 4th; cpu_hold falls the cycle after.
- In RUN, drive cpu_done with RAM holding 0x0005,0x00AA,0x0123,0x00FF at 0x10..0x13 and m_ready=1 -> m_data 0x05,0xAA,then 0x23 (or 0xFF with FRAME_OUT_SAT_EN),0xFF; frame_done pulses once; state returns to IDLE.
- Backpressure: hold m_ready=0 for 5 cycles on pixel 2 -> m_valid=1 and m_data constant; no new ram_re until the handshake.
- Gapped input: s_valid toggling 1,0,1,0 -> ram_we only on the accepted cycles; addresses stay contiguous.
- BASE_ADDR=0xFE, IMG_WORDS=4 -> write addresses 0xFE,0xFF,0x00,0x01 (wrap).
- Assert rst during OUT of pixel 2 -> all outputs at reset values asynchronously; a new start_load then runs a full frame correctly.

Source files
------------

// File: rtl/image_frame_loader.sv
// Frame loader: streams pixels into the processor data RAM, runs the processor, then streams the result back out.
// Build option FRAME_OUT_SAT_EN: read-back words above 255 saturate to 8'hFF instead of being truncated.
module image_frame_loader #(
    parameter int IMG_WORDS = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_load,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        cpu_hold,
    input  logic        cpu_done,
    output logic        ram_we,
    output logic        ram_re,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        busy,
    output logic        frame_done
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, RD_ISSUE, RD_WAIT, OUT} state_t;

    localparam logic [8:0] LAST_IDX = 9'(IMG_WORDS - 1);
    localparam logic [7:0] BASE     = 8'(BASE_ADDR);

    state_t     state, state_next;
    logic [8:0] count;
    logic       s_hs, m_hs, last_px;

    // Buffer addresses wrap modulo 256, so only the low count bits matter here.
    function automatic logic [7:0] frame_addr(input logic [7:0] idx);
        return BASE + idx;
    endfunction

    function automatic logic [7:0] out_pixel(input logic [15:0] word);
`ifdef FRAME_OUT_SAT_EN
        if (word > 16'd255) return 8'hFF;
`endif
        return 8'(word);
    endfunction

    assign s_hs    = s_valid && (state == LOAD);
    assign m_hs    = m_valid && m_ready && (state == OUT);
    assign last_px = (count == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_load) state_next = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_hs && last_px) state_next = RUN;
            end
            RUN: begin
                cpu_hold = 1'b0;
                if (cpu_done) state_next = RD_ISSUE;
            end
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT:  state_next = OUT;
            OUT: begin
                if (m_hs) state_next = last_px ? IDLE : RD_ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The read strobe is registered on entry to RD_ISSUE so the RAM word lands during RD_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            ram_addr   <= BASE;
            ram_wdata  <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            frame_done <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_load) count <= '0;
                end
                LOAD: begin
                    if (s_hs) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= frame_addr(count[7:0]);
                        ram_wdata <= {8'h00, s_data};
                        count     <= count + 9'd1;
                    end
                end
                RUN: begin
                    if (cpu_done) begin
                        count    <= '0;
                        ram_re   <= 1'b1;
                        ram_addr <= frame_addr(8'd0);
                    end
                end
                RD_WAIT: begin
                    m_data  <= out_pixel(ram_rdata);
                    m_valid <= 1'b1;
                end
                OUT: begin
                    if (m_hs) begin
                        m_valid <= 1'b0;
                        count   <= count + 9'd1;
                        if (last_px) begin
                            frame_done <= 1'b1;
                        end else begin
                            ram_re   <= 1'b1;
                            ram_addr <= frame_addr(count[7:0] + 8'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_loader.sv
// Scoreboard bench for image_frame_loader: 4-pixel frames at a buffer base that wraps past address 0xFF.
`timescale 1ns/1ps
module tb_image_frame_loader;
    localparam int IMG  = 4;
    localparam int BASE = 'hFE;

    logic        clk = 1'b0;
    logic        rst, start_load, s_valid, s_ready, cpu_hold, cpu_done;
    logic [7:0]  s_data, ram_addr, m_data;
    logic        ram_we, ram_re, m_valid, m_ready, busy, frame_done;
    logic [15:0] ram_wdata, ram_rdata;

    logic        proc_we;
    logic [7:0]  proc_addr;
    logic [15:0] proc_wdata;
    logic [15:0] mem [256];

    logic [7:0]  in_px   [IMG];
    logic [15:0] proc_px [IMG];

    logic [23:0] exp_w [$];
    logic [7:0]  exp_r [$];
    logic [7:0]  exp_px [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    image_frame_loader #(.IMG_WORDS(IMG), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start_load(start_load),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cpu_hold(cpu_hold), .cpu_done(cpu_done),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .frame_done(frame_done)
    );

    // Data RAM with one-cycle read latency; the processor side writes through proc_we.
    always @(posedge clk) begin
        if (ram_we)  mem[ram_addr]  <= ram_wdata;
        if (proc_we) mem[proc_addr] <= proc_wdata;
        if (ram_re)  ram_rdata      <= mem[ram_addr];
    end

    function automatic logic [7:0] ref_px(input logic [15:0] v);
`ifdef FRAME_OUT_SAT_EN
        if (v > 16'd255) return 8'hFF;
`endif
        return 8'(v % 16'd256);
    endfunction

    function automatic logic [7:0] buf_addr(input int k);
        return 8'((BASE + k) % 256);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected no event at %0t", name, act, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"},    s_ready,    0);
        check({tag, "_m_valid"},    m_valid,    0);
        check({tag, "_m_data"},     m_data,     0);
        check({tag, "_ram_we"},     ram_we,     0);
        check({tag, "_ram_re"},     ram_re,     0);
        check({tag, "_ram_addr"},   ram_addr,   buf_addr(0));
        check({tag, "_ram_wdata"},  ram_wdata,  0);
        check({tag, "_cpu_hold"},   cpu_hold,   1);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, a read or an output pixel.
    int          out_idx   = 0;
    bit          done_due  = 1'b0;
    bit          hold_prev = 1'b0;
    logic [7:0]  data_prev;
    logic [23:0] wexp;
    always @(negedge clk) begin
        if (rst) begin
            out_idx   = 0;
            done_due  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (frame_done || done_due) check("frame_done", frame_done, done_due);
            done_due = 1'b0;
            if (ram_we || ram_re) check("we_re_exclusive", ram_we & ram_re, 0);
            if (ram_we) begin
                if (exp_w.size() == 0) flag("spurious_write", {ram_addr, ram_wdata});
                else begin
                    wexp = exp_w.pop_front();
                    check("wr_addr", ram_addr, wexp[23:16]);
                    check("wr_data", ram_wdata, wexp[15:0]);
                end
            end
            if (ram_re) begin
                check("re_while_valid", m_valid, 0);
                if (exp_r.size() == 0) flag("spurious_read", ram_addr);
                else check("rd_addr", ram_addr, exp_r.pop_front());
            end
            if (m_valid) begin
                if (hold_prev) check("m_data_stable", m_data, data_prev);
                if (m_ready) begin
                    if (exp_px.size() == 0) flag("spurious_pixel", m_data);
                    else check("m_data", m_data, exp_px.pop_front());
                    out_idx++;
                    if (out_idx == IMG) begin
                        out_idx  = 0;
                        done_due = 1'b1;
                    end
                    hold_prev = 1'b0;
                end else begin
                    hold_prev = 1'b1;
                    data_prev = m_data;
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    task automatic randomize_frame();
        for (int k = 0; k < IMG; k++) begin
            in_px[k]   = 8'($urandom);
            proc_px[k] = 16'($urandom_range(0, 511));
        end
    endtask

    // gap_mode: 0 back-to-back, 1 alternating gaps, 2 random gaps and random m_ready.
    task automatic run_frame(input int gap_mode, input int bp_pix, input int bp_len, input bit abort_at_bp);
        int pix;
        int held;
        bit hs_now;
        bit seen_done;
        s_valid = 1'b1; s_data = 8'hEE; cpu_done = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_hold", cpu_hold, 1);
        s_valid = 1'b0; cpu_done = 1'b0; start_load = 1'b1;
        tick();
        start_load = 1'b0;
        check("load_busy", busy, 1);
        for (int k = 0; k < IMG; k++) begin
            if ((gap_mode == 1 && k > 0) || (gap_mode == 2 && $urandom_range(1) == 1)) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_data  = in_px[k];
            check("s_ready_load", s_ready, 1);
            exp_w.push_back({buf_addr(k), 8'h00, in_px[k]});
            tick();
        end
        s_data = 8'hDD;
        check("s_ready_run", s_ready, 0);
        check("hold_run", cpu_hold, 0);
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < IMG; k++) begin
            proc_we    = 1'b1;
            proc_addr  = buf_addr(k);
            proc_wdata = proc_px[k];
            exp_r.push_back(buf_addr(k));
            exp_px.push_back(ref_px(proc_px[k]));
            tick();
        end
        proc_we = 1'b0;
        check("hold_before_done", cpu_hold, 0);
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        check("hold_after_done", cpu_hold, 1);
        pix = 0; held = 0; seen_done = 1'b0;
        for (int budget = 0; budget < 200 && !seen_done; budget++) begin
            if (abort_at_bp && m_valid && pix == bp_pix && held == bp_len) begin
                #3 rst = 1'b1;
                #1;
                check_reset("abort");
                exp_w.delete(); exp_r.delete(); exp_px.delete();
                m_ready = 1'b0;
                tick(); tick();
                rst = 1'b0;
                tick();
                return;
            end
            if (m_valid && pix == bp_pix && held < bp_len) begin
                m_ready = 1'b0;
                held++;
            end else begin
                m_ready = (gap_mode == 2) ? 1'($urandom_range(1)) : 1'b1;
            end
            hs_now = m_valid && m_ready;
            tick();
            if (hs_now) pix++;
            if (frame_done) begin
                seen_done = 1'b1;
                check("idle_after_frame", busy, 0);
            end
        end
        m_ready = 1'b0;
        if (!seen_done) flag("frame_done_timeout", pix);
        tick();
        check("pixels_left", exp_px.size(), 0);
        check("reads_left", exp_r.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start_load = 1'b0; s_valid = 1'b0; s_data = '0;
        cpu_done = 1'b0; m_ready = 1'b0;
        proc_we = 1'b0; proc_addr = '0; proc_wdata = '0;
        tick(); tick();
        check_reset("por");
        rst = 1'b0;
        tick();

        in_px   = '{8'h11, 8'h22, 8'h33, 8'h44};
        proc_px = '{16'h0005, 16'h00AA, 16'h0123, 16'h00FF};
        run_frame(0, -1, 0, 1'b0);

        randomize_frame();
        run_frame(1, 2, 5, 1'b0);

        randomize_frame();
        run_frame(2, 2, 3, 1'b1);

        randomize_frame();
        run_frame(0, -1, 0, 1'b0);

        for (int f = 0; f < 3; f++) begin
            randomize_frame();
            run_frame(2, 1, 2, 1'b0);
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
